// File: rtl/sram_controller.sv
// Word-wide MEM-stage port onto a 16-bit asynchronous SRAM: each 32-bit access
// becomes a low then a high half-word access, each held for WAIT_CYCLES cycles.
module sram_controller #(
  parameter int unsigned ADDR_BASE   = 1024,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MEMread,
  input  logic        MEMwrite,
  input  logic [31:0] address,
  input  logic [31:0] value,
  output logic [31:0] MEM_result,
  output logic        ready,
  output logic [17:0] SRAM_ADDR,
  output logic [15:0] SRAM_DQ_out,
  input  logic [15:0] SRAM_DQ_in,
  output logic        SRAM_DQ_oe,
  output logic        SRAM_WE_N
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOW,
    S_HIGH,
    S_DONE
  } state_t;

  state_t      state_reg, state_next;
  logic [3:0]  cnt_reg, cnt_next;
  logic        op_wr_reg, op_wr_next;
  logic [16:0] widx_reg, widx_next;
  logic [31:0] value_reg, value_next;
  logic [15:0] lo_reg, lo_next;
  logic [15:0] hi_reg, hi_next;

  logic [17:0] sram_addr_next;
  logic [15:0] sram_dq_out_next;
  logic        sram_dq_oe_next;
  logic        sram_we_n_next;

  logic [31:0] offset;
  logic        request;
  logic        last_cycle;
  logic        drive_next;
  logic        unused_bits;

  // The word index wraps mod 2^32 before the upper bits are dropped.
  assign offset      = address - ADDR_BASE;
  assign unused_bits = ^{offset[31:19], offset[1:0]};
  assign request     = MEMread | MEMwrite;
  assign last_cycle  = (cnt_reg == 4'(WAIT_CYCLES - 1));

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    op_wr_next = op_wr_reg;
    widx_next  = widx_reg;
    value_next = value_reg;
    lo_next    = lo_reg;
    hi_next    = hi_reg;
    ready      = 1'b0;
    unique case (state_reg)
      S_IDLE: begin
        ready = ~request;
        if (request) begin
          op_wr_next = MEMwrite;
          widx_next  = offset[18:2];
          value_next = value;
          cnt_next   = 4'd0;
          state_next = S_LOW;
        end
      end
      S_LOW: begin
        if (last_cycle) begin
          cnt_next   = 4'd0;
          state_next = S_HIGH;
          if (!op_wr_reg) lo_next = SRAM_DQ_in;
        end else begin
          cnt_next = cnt_reg + 4'd1;
        end
      end
      S_HIGH: begin
        if (last_cycle) begin
          cnt_next   = 4'd0;
          state_next = S_DONE;
          if (!op_wr_reg) hi_next = SRAM_DQ_in;
        end else begin
          cnt_next = cnt_reg + 4'd1;
        end
      end
      S_DONE: begin
        ready      = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Pad controls are decoded from the next state so they register cleanly
  // and line up exactly with the phase they belong to.
  always_comb begin
    sram_addr_next   = SRAM_ADDR;
    sram_dq_out_next = 16'h0000;
    drive_next       = 1'b0;
    if (state_next == S_LOW) begin
      sram_addr_next   = {widx_next, 1'b0};
      drive_next       = op_wr_next;
      sram_dq_out_next = op_wr_next ? value_next[15:0] : 16'h0000;
    end else if (state_next == S_HIGH) begin
      sram_addr_next   = {widx_next, 1'b1};
      drive_next       = op_wr_next;
      sram_dq_out_next = op_wr_next ? value_next[31:16] : 16'h0000;
    end
    sram_dq_oe_next = drive_next;
    sram_we_n_next  = ~drive_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= S_IDLE;
      cnt_reg     <= 4'd0;
      op_wr_reg   <= 1'b0;
      widx_reg    <= 17'd0;
      value_reg   <= 32'd0;
      lo_reg      <= 16'h0000;
      hi_reg      <= 16'h0000;
      SRAM_ADDR   <= 18'd0;
      SRAM_DQ_out <= 16'h0000;
      SRAM_DQ_oe  <= 1'b0;
      SRAM_WE_N   <= 1'b1;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      op_wr_reg   <= op_wr_next;
      widx_reg    <= widx_next;
      value_reg   <= value_next;
      lo_reg      <= lo_next;
      hi_reg      <= hi_next;
      SRAM_ADDR   <= sram_addr_next;
      SRAM_DQ_out <= sram_dq_out_next;
      SRAM_DQ_oe  <= sram_dq_oe_next;
      SRAM_WE_N   <= sram_we_n_next;
    end
  end

  assign MEM_result = (state_reg == S_DONE && !op_wr_reg) ? {hi_reg, lo_reg} : 32'd0;

endmodule

// File: tb/tb_sram_controller.sv
// Bench for sram_controller: two instances (W=2, W=1) each on a behavioural
// half-word SRAM, checked against a word-level reference memory.
module tb_sram_controller;

  localparam int unsigned ADDR_BASE = 1024;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd       [2];
  logic        wr       [2];
  logic [31:0] addr_s   [2];
  logic [31:0] val_s    [2];
  logic [31:0] result   [2];
  logic        ready_o  [2];
  logic [17:0] sram_addr[2];
  logic [15:0] dq_out   [2];
  logic [15:0] dq_in    [2];
  logic        oe       [2];
  logic        we_n     [2];

  int tests = 0;
  int fails = 0;

  logic [31:0] ref_mem [int];

  always #5 clk = ~clk;

  // Power-up contents of the SRAM, a fixed scramble of the half-word address.
  function automatic logic [15:0] pat(input logic [17:0] a);
    logic [31:0] p;
    p = ({14'b0, a} * 32'd40503) >> 3;
    return p[15:0] ^ 16'h5A5A;
  endfunction

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    localparam int unsigned W = (gi == 0) ? 2 : 1;
    logic [15:0] smem [0:262143];

    sram_controller #(.ADDR_BASE(ADDR_BASE), .WAIT_CYCLES(W)) u_dut (
      .clk(clk), .rst(rst), .MEMread(rd[gi]), .MEMwrite(wr[gi]),
      .address(addr_s[gi]), .value(val_s[gi]), .MEM_result(result[gi]),
      .ready(ready_o[gi]), .SRAM_ADDR(sram_addr[gi]), .SRAM_DQ_out(dq_out[gi]),
      .SRAM_DQ_in(dq_in[gi]), .SRAM_DQ_oe(oe[gi]), .SRAM_WE_N(we_n[gi])
    );

    initial for (int i = 0; i < 262144; i++) smem[i] <= pat(18'(i));

    // A reset edge aborts the half-word write that is on the pins.
    always @(posedge clk)
      if (!rst && !we_n[gi]) smem[sram_addr[gi]] <= dq_out[gi];

    assign dq_in[gi] = smem[sram_addr[gi]];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int key(input int k, input logic [16:0] wi);
    return k * 131072 + int'(wi);
  endfunction

  function automatic logic [31:0] ref_rd(input int k, input logic [16:0] wi);
    if (ref_mem.exists(key(k, wi))) return ref_mem[key(k, wi)];
    return {pat({wi, 1'b1}), pat({wi, 1'b0})};
  endfunction

  function automatic logic [16:0] word_of(input logic [31:0] a);
    logic [31:0] o;
    o = (a - ADDR_BASE) >> 2;
    return o[16:0];
  endfunction

  // Called one step after an edge with instance k in IDLE; returns in DONE.
  task automatic txn(input int k, input bit w_op, input bit r_op,
                     input logic [31:0] a, input logic [31:0] v);
    int w;
    bit hi;
    logic [16:0] wi;
    logic [31:0] expw;
    w  = (k == 0) ? 2 : 1;
    wi = word_of(a);
    expw = ref_rd(k, wi);
    wr[k] = w_op; rd[k] = r_op; addr_s[k] = a; val_s[k] = v;
    #1 chk("req_ready", 32'(ready_o[k]), 32'd0);
    for (int c = 1; c <= 2 * w; c++) begin
      @(posedge clk); #1;
      hi = (c > w);
      chk("phase_ready", 32'(ready_o[k]), 32'd0);
      chk("sram_addr", 32'(sram_addr[k]), 32'({wi, hi}));
      chk("we_n", 32'(we_n[k]), 32'(!w_op));
      chk("dq_oe", 32'(oe[k]), 32'(w_op));
      if (w_op) chk("dq_out", 32'(dq_out[k]), hi ? {16'h0, v[31:16]} : {16'h0, v[15:0]});
    end
    @(posedge clk); #1;
    chk("done_ready", 32'(ready_o[k]), 32'd1);
    chk("mem_result", result[k], w_op ? 32'd0 : expw);
    chk("done_we_n", 32'(we_n[k]), 32'd1);
    chk("done_oe", 32'(oe[k]), 32'd0);
    if (w_op) ref_mem[key(k, wi)] = v;
    $display("[TB] inst=%0d %s addr=%h widx=%0d data=%h", k, w_op ? "write" : "read ",
             a, wi, w_op ? v : result[k]);
  endtask

  task automatic idle_step(input int k);
    wr[k] = 1'b0; rd[k] = 1'b0;
    @(posedge clk); #1;
    chk("idle_ready", 32'(ready_o[k]), 32'd1);
    chk("idle_we_n", 32'(we_n[k]), 32'd1);
    chk("idle_oe", 32'(oe[k]), 32'd0);
    chk("idle_result", result[k], 32'd0);
  endtask

  initial begin
    logic [31:0] a, v, w32, old;
    logic [16:0] wi;
    int k, op;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      rd[i] = 1'b0; wr[i] = 1'b0; addr_s[i] = 32'd0; val_s[i] = 32'd0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("rst_ready", 32'(ready_o[i]), 32'd1);
      chk("rst_addr", 32'(sram_addr[i]), 32'd0);
      chk("rst_dq_out", 32'(dq_out[i]), 32'd0);
      chk("rst_oe", 32'(oe[i]), 32'd0);
      chk("rst_we_n", 32'(we_n[i]), 32'd1);
      chk("rst_result", result[i], 32'd0);
    end
    rst = 1'b0;
    repeat (5) idle_step(0);

    // Directed sequence on the W=2 instance.
    txn(0, 1'b1, 1'b0, 32'd1024, 32'hDEADBEEF); idle_step(0);
    txn(0, 1'b0, 1'b1, 32'd1024, 32'h0);        idle_step(0);
    txn(0, 1'b0, 1'b1, 32'd1028, 32'h0);        idle_step(0);
    txn(0, 1'b1, 1'b1, 32'd1032, 32'h12345678); idle_step(0);
    txn(0, 1'b0, 1'b1, 32'd1032, 32'h0);        idle_step(0);

    // Reset during the first HIGH cycle of a write: only the low half lands.
    a = 32'd1036; v = 32'hCAFEF00D; wi = word_of(a);
    old = ref_rd(0, wi);
    wr[0] = 1'b1; addr_s[0] = a; val_s[0] = v;
    repeat (3) @(posedge clk);
    #1 chk("mid_high_addr", 32'(sram_addr[0]), 32'({wi, 1'b1}));
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_we_n", 32'(we_n[0]), 32'd1);
    chk("mid_rst_oe", 32'(oe[0]), 32'd0);
    chk("mid_rst_ready", 32'(ready_o[0]), 32'd0);
    wr[0] = 1'b0;
    #1 chk("mid_rst_ready_norq", 32'(ready_o[0]), 32'd1);
    rst = 1'b0;
    @(posedge clk); #1;
    ref_mem[key(0, wi)] = {old[31:16], v[15:0]};
    $display("[TB] inst=0 write addr=%h abandoned by reset", a);
    txn(0, 1'b0, 1'b1, a, 32'h0); idle_step(0);

    // Back-to-back on the W=1 instance: the next request is up during DONE.
    txn(1, 1'b0, 1'b1, 32'd1024, 32'h0);
    wr[1] = 1'b1; rd[1] = 1'b0; addr_s[1] = 32'd2000; val_s[1] = 32'hA5C3_0F1E;
    @(posedge clk); #1;
    txn(1, 1'b1, 1'b0, 32'd2000, 32'hA5C3_0F1E); idle_step(1);
    txn(1, 1'b0, 1'b1, 32'd2000, 32'h0);         idle_step(1);

    // Random traffic over a small aliased pool of word indices.
    for (int n = 0; n < 40; n++) begin
      k  = int'($urandom_range(0, 1));
      op = int'($urandom_range(0, 2));
      w32 = $urandom_range(0, 7) + ($urandom_range(0, 3) << 17);
      if ($urandom_range(0, 4) == 0) w32 = 32'hFFFF_FFF8 + $urandom_range(0, 7);
      a = ADDR_BASE + (w32 << 2) + $urandom_range(0, 3);
      v = $urandom;
      txn(k, op != 0, op != 1, a, v);
      idle_step(k);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
